// File: rtl/key_cmd_scheduler_if.sv
// Command port between the front-panel scheduler and the filter coprocessor.
// The scheduler is the master: it offers opcodes and abort requests, the
// coprocessor answers with ready and a done pulse.
interface key_cmd_scheduler_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       cop_done;
  logic       abort_pulse;

  modport master (
    output cmd_valid,
    output cmd_op,
    output abort_pulse,
    input  cmd_ready,
    input  cop_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  abort_pulse,
    output cmd_ready,
    output cop_done
  );
endinterface

// File: rtl/key_cmd_scheduler.sv
// Front-panel controller: debounces four push-buttons on a shared sample
// tick, turns clean presses into pending events, serves them by fixed
// priority and runs the command handshake / done / timeout tracking towards
// the image-filter coprocessor.
module key_cmd_scheduler #(
  parameter int TICK_DIV      = 250000,
  parameter int STABLE_TICKS  = 3,
  parameter int OP_MAX        = 5,
  parameter int TIMEOUT_TICKS = 400
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [3:0]                 i_key_n,
  key_cmd_scheduler_if.master        cmd_if,
  output logic [2:0]                 o_sel_op,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_TICKS - 1);
  localparam logic [2:0]    OP_TOP    = 3'(OP_MAX);

  // Key indices: 0=START 1=NEXT 2=PREV 3=ABORT
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  logic [TW-1:0]                 r_tick_cnt;
  logic                          w_tick;
  logic [3:0]                    r_sync1;
  logic [3:0]                    r_sync2;
  logic [3:0][STABLE_TICKS-1:0]  r_hist;
  logic [3:0]                    r_deb;
  logic [3:0]                    w_deb_nxt;
  logic [3:0]                    w_rise;
  logic [3:0]                    r_pend;
  logic [3:0]                    w_clr;
  logic [3:0]                    w_pend_nxt;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [2:0]                    r_sel_op;
  logic [2:0]                    w_sel_nxt;
  logic                          r_cmd_valid;
  logic                          w_valid_nxt;
  logic [2:0]                    r_cmd_op;
  logic [2:0]                    w_op_nxt;
  logic                          r_abort_pulse;
  logic                          w_abort_nxt;
  logic                          r_timeout;
  logic                          w_timeout_nxt;
  logic [CW-1:0]                 r_to_cnt;
  logic [CW-1:0]                 w_to_cnt_nxt;
  logic                          r_busy;
  logic                          w_hs;

  assign w_tick = (r_tick_cnt == TICK_LAST);
  assign w_hs   = r_cmd_valid & cmd_if.cmd_ready;

  // Free-running divider producing the one-cycle debounce sample tick
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Synchronise the raw keys (active-high after inversion) and shift sample histories on tick
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_hist  <= '0;
      r_deb   <= 4'b0000;
    end else begin
      r_sync1 <= ~i_key_n;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_nxt;
      if (w_tick) begin
        for (int i = 0; i < 4; i++) begin
          r_hist[i] <= (r_hist[i] << 1) | STABLE_TICKS'(r_sync2[i]);
        end
      end else begin
        r_hist <= r_hist;
      end
    end
  end

  // Accept a level change only when the whole history agrees; flag presses
  always_comb begin
    w_deb_nxt = r_deb;
    w_rise    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((&r_hist[i]) && !r_deb[i]) begin
        w_deb_nxt[i] = 1'b1;
        w_rise[i]    = 1'b1;
      end else if (!(|r_hist[i]) && r_deb[i]) begin
        w_deb_nxt[i] = 1'b0;
      end else begin
        w_deb_nxt[i] = r_deb[i];
      end
    end
  end

  // Event arbitration, command handshake, done/timeout/abort sequencing
  always_comb begin
    w_state_nxt   = r_state;
    w_clr         = 4'b0000;
    w_sel_nxt     = r_sel_op;
    w_valid_nxt   = r_cmd_valid;
    w_op_nxt      = r_cmd_op;
    w_abort_nxt   = 1'b0;
    w_timeout_nxt = r_timeout;
    w_to_cnt_nxt  = r_to_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_pend[3]) begin
          // Nothing to abort in IDLE: just consume the event
          w_clr[3] = 1'b1;
        end else if (r_pend[0]) begin
          w_clr[0]      = 1'b1;
          w_op_nxt      = r_sel_op;
          w_valid_nxt   = 1'b1;
          w_timeout_nxt = 1'b0;
          w_state_nxt   = S_ISSUE;
        end else if (r_pend[1]) begin
          w_clr[1]  = 1'b1;
          w_sel_nxt = (r_sel_op == OP_TOP) ? 3'd0 : r_sel_op + 3'd1;
        end else if (r_pend[2]) begin
          w_clr[2]  = 1'b1;
          w_sel_nxt = (r_sel_op == 3'd0) ? OP_TOP : r_sel_op - 3'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_hs) begin
          // Handshake completes first; a coinciding abort stays pending
          // and is served from WAIT_DONE on the next cycle
          w_valid_nxt  = 1'b0;
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_WAIT_DONE;
        end else if (r_pend[3]) begin
          w_clr[3]    = 1'b1;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (cmd_if.cop_done) begin
          // Done beats both a coinciding abort and the final timeout tick
          w_clr[3]    = r_pend[3];
          w_state_nxt = S_IDLE;
        end else if (r_pend[3]) begin
          w_clr[3]    = 1'b1;
          w_abort_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_to_cnt_nxt = r_to_cnt + CW'(1);
          if (r_to_cnt == TO_LAST) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_DONE;
          end
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    w_pend_nxt = (r_pend & ~w_clr) | w_rise;
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pend        <= 4'b0000;
      r_sel_op      <= 3'd0;
      r_cmd_valid   <= 1'b0;
      r_cmd_op      <= 3'd0;
      r_abort_pulse <= 1'b0;
      r_timeout     <= 1'b0;
      r_to_cnt      <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend        <= w_pend_nxt;
      r_sel_op      <= w_sel_nxt;
      r_cmd_valid   <= w_valid_nxt;
      r_cmd_op      <= w_op_nxt;
      r_abort_pulse <= w_abort_nxt;
      r_timeout     <= w_timeout_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
    end
  end

  assign cmd_if.cmd_valid   = r_cmd_valid;
  assign cmd_if.cmd_op      = r_cmd_op;
  assign cmd_if.abort_pulse = r_abort_pulse;
  assign o_sel_op           = r_sel_op;
  assign o_busy             = r_busy;
  assign o_timeout          = r_timeout;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: randomized key presses and handshake timing,
// checked against an event-level model of the opcode selector and the
// command/abort/timeout rules.
module tb_key_cmd_scheduler;
  localparam int TICK_DIV      = 4;
  localparam int STABLE_TICKS  = 3;
  localparam int OP_MAX        = 5;
  localparam int TIMEOUT_TICKS = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_n;
  logic [2:0] sel_op;
  logic       busy;
  logic       timeout;

  int errors;
  int checks;
  int model_sel;

  key_cmd_scheduler_if bus();

  key_cmd_scheduler #(
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .OP_MAX       (OP_MAX),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_key_n  (key_n),
    .cmd_if   (bus),
    .o_sel_op (sel_op),
    .o_busy   (busy),
    .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_next(input int s);
    return (s == OP_MAX) ? 0 : s + 1;
  endfunction

  function automatic int ref_prev(input int s);
    return (s == 0) ? OP_MAX : s - 1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    key_n = 4'hF;
    bus.cmd_ready = 1'b0;
    bus.cop_done  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_sel = 0;
  endtask

  task automatic press(input int idx);
    key_n[idx] = 1'b0;
    repeat (20 + $urandom_range(0, 8)) @(negedge clk);
    key_n[idx] = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic start_cmd(output bit ok);
    ok = 1'b0;
    key_n[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    key_n[0] = 1'b1;
  endtask

  task automatic accept();
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
  endtask

  task automatic pulse_done();
    bus.cop_done = 1'b1;
    @(negedge clk);
    bus.cop_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sel_op !== 3'd0) begin errors++; $display("FAIL reset_sel_op: got %0d want 0", sel_op); end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
    checks++; if (bus.cmd_op !== 3'd0) begin errors++; $display("FAIL reset_cmd_op: got %0d want 0", bus.cmd_op); end
    checks++; if (bus.abort_pulse !== 1'b0) begin errors++; $display("FAIL reset_abort_pulse: got %b want 0", bus.abort_pulse); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_bounce();
    bit changed;
    int lat;
    do_reset();
    changed = 1'b0;
    for (int ph = 0; ph < 8; ph++) begin
      key_n[1] = ph[0];
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (sel_op !== 3'd0) changed = 1'b1;
      end
    end
    key_n[1] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (lat < 0 && sel_op !== 3'd0) lat = c;
    end
    model_sel = ref_next(0);
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL bounce_quiet: sel_op changed during bounce=%b want 0", changed); end
    checks++; if (lat < 10 || lat > 20) begin errors++; $display("FAIL bounce_latency: got %0d clk want 10..20", lat); end
    checks++; if (sel_op !== 3'(model_sel)) begin errors++; $display("FAIL bounce_single_event: sel_op=%0d want %0d", sel_op, model_sel); end
    key_n[1] = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_next_prev();
    int k;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      press(1);
      model_sel = ref_next(model_sel);
      checks++; if (sel_op !== 3'(model_sel)) begin errors++; $display("FAIL next_step%0d: sel_op=%0d want %0d", n, sel_op, model_sel); end
    end
    press(2);
    model_sel = ref_prev(model_sel);
    checks++; if (sel_op !== 3'(model_sel)) begin errors++; $display("FAIL prev_wrap: sel_op=%0d want %0d", sel_op, model_sel); end
    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(1, 2);
      press(k);
      model_sel = (k == 1) ? ref_next(model_sel) : ref_prev(model_sel);
      checks++; if (sel_op !== 3'(model_sel)) begin errors++; $display("FAIL random_sel%0d key%0d: sel_op=%0d want %0d", n, k, sel_op, model_sel); end
    end
  endtask

  task automatic test_handshake();
    int target;
    int dly;
    bit ok;
    bit stable;
    for (int it = 0; it < 3; it++) begin
      target = (it == 0) ? 2 : $urandom_range(0, OP_MAX);
      while (model_sel != target) begin
        press(1);
        model_sel = ref_next(model_sel);
      end
      checks++; if (sel_op !== 3'(target)) begin errors++; $display("FAIL hs_select%0d: sel_op=%0d want %0d", it, sel_op, target); end
      start_cmd(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hs_valid_rise%0d: cmd_valid seen=%b want 1", it, ok); end
      checks++; if (bus.cmd_op !== 3'(target)) begin errors++; $display("FAIL hs_cmd_op%0d: got %0d want %0d", it, bus.cmd_op, target); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_issue%0d: got %b want 1", it, busy); end
      dly = (it == 0) ? 10 : $urandom_range(0, 10);
      stable = 1'b1;
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'(target)) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hs_hold%0d: valid/op stable=%b want 1", it, stable); end
      accept();
      checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL hs_drop%0d: cmd_valid=%b want 0", it, bus.cmd_valid); end
      repeat ($urandom_range(0, 6)) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_busy_wait%0d: got %b want 1", it, busy); end
      pulse_done();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle%0d: busy=%b want 0", it, busy); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL hs_timeout%0d: got %b want 0", it, timeout); end
      repeat (24) @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    start_cmd(ok);
    accept();
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        n = c;
        break;
      end
    end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: timeout=%b want 1", timeout); end
    checks++; if (n < 27 || n > 34) begin errors++; $display("FAIL to_latency: busy low after %0d clk want 27..34", n); end
    repeat (24) @(negedge clk);
    start_cmd(ok);
    checks++; if (ok !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_clear: valid=%b timeout=%b want 1/0", ok, timeout); end
    accept();
    repeat (3) @(negedge clk);
    pulse_done();
    repeat (24) @(negedge clk);
  endtask

  task automatic abort_run(input int done_at, output int pulses, output int pidx,
                           output bit busy_after, output bit busy_end, output bit ok);
    pulses = 0;
    pidx = -1;
    busy_after = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    start_cmd(ok);
    accept();
    key_n[3] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.abort_pulse === 1'b1) begin
        pulses++;
        if (pidx < 0) pidx = i;
      end
      if (pidx >= 0 && i == pidx + 1) busy_after = busy;
      bus.cop_done = (i == done_at);
    end
    bus.cop_done = 1'b0;
    busy_end = busy;
    key_n[3] = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_abort();
    int p;
    int idx;
    int idx2;
    bit ba;
    bit be;
    bit ok;
    abort_run(-1, p, idx, ba, be, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_start: cmd_valid seen=%b want 1", ok); end
    checks++; if (p != 1) begin errors++; $display("FAIL abort_pulse_width: %0d pulse cycles want 1", p); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL abort_busy: busy after pulse=%b want 0", ba); end
    abort_run((idx >= 1) ? idx - 1 : 0, p, idx2, ba, be, ok);
    checks++; if (p != 0) begin errors++; $display("FAIL abort_done_wins: %0d pulse cycles want 0", p); end
    checks++; if (be !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL abort_done_idle: busy=%b timeout=%b want 0/0", be, timeout); end
  endtask

  task automatic test_abort_issue();
    bit ok;
    bit dropped;
    int p;
    start_cmd(ok);
    key_n[3] = 1'b0;
    dropped = 1'b0;
    p = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.abort_pulse === 1'b1) p++;
      if (!dropped && bus.cmd_valid === 1'b0) dropped = 1'b1;
    end
    checks++; if (dropped !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL issue_abort: dropped=%b busy=%b want 1/0", dropped, busy); end
    checks++; if (p != 0) begin errors++; $display("FAIL issue_abort_pulse: %0d pulse cycles want 0", p); end
    key_n[3] = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_priority();
    int pre;
    bit ok;
    pre = model_sel;
    key_n[0] = 1'b0;
    key_n[1] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    key_n[0] = 1'b1;
    key_n[1] = 1'b1;
    checks++; if (ok !== 1'b1 || bus.cmd_op !== 3'(pre)) begin errors++; $display("FAIL prio_start_first: valid=%b op=%0d want 1/%0d", ok, bus.cmd_op, pre); end
    checks++; if (sel_op !== 3'(pre)) begin errors++; $display("FAIL prio_next_deferred: sel_op=%0d want %0d", sel_op, pre); end
    accept();
    repeat (4) @(negedge clk);
    checks++; if (sel_op !== 3'(pre)) begin errors++; $display("FAIL prio_next_wait: sel_op=%0d want %0d", sel_op, pre); end
    pulse_done();
    repeat (4) @(negedge clk);
    model_sel = ref_next(pre);
    checks++; if (sel_op !== 3'(model_sel)) begin errors++; $display("FAIL prio_next_applied: sel_op=%0d want %0d", sel_op, model_sel); end
    repeat (24) @(negedge clk);
    start_cmd(ok);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ok !== 1'b1 || bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_valid: started=%b cmd_valid=%b want 1/0", ok, bus.cmd_valid); end
    checks++; if (sel_op !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_issue_state: sel_op=%0d busy=%b want 0/0", sel_op, busy); end
    rst_n = 1'b1;
    model_sel = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_sel = 0;
    rst_n = 1'b1;
    key_n = 4'hF;
    bus.cmd_ready = 1'b0;
    bus.cop_done  = 1'b0;
    test_reset();
    test_bounce();
    test_next_prev();
    test_handshake();
    test_timeout();
    test_abort();
    test_abort_issue();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
